// File: rtl/alu_vector_recorder.sv
// alu_vector_recorder: packs ALU transactions into 103-bit vector words,
// buffers them in a show-ahead FIFO and drains them over valid/ready.
//
// Ports:
//   clk, reset          clock, async active-low reset
//   cap_valid/ready     capture handshake; ALU fields sampled on accept
//   ALUControl, a, b,
//   Result, ALUFlags    ALU transaction fields
//   vec_valid/ready     output stream handshake
//   vec_data            packed word {ALUControl, a, b, Result, ALUFlags}
//   level               words currently buffered
//   cap_count           accepted captures since reset (wraps)
//   drop_count          captures discarded while full (saturates)
//
// Build option: define ALU_REC_DROP_EN for lossy mode (cap_ready tied high,
// captures at full are dropped and counted). Undefined = lossless mode.
module alu_vector_recorder #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cap_valid,
    output logic                     cap_ready,
    input  logic [2:0]               ALUControl,
    input  logic [31:0]              a,
    input  logic [31:0]              b,
    input  logic [31:0]              Result,
    input  logic [3:0]               ALUFlags,
    output logic                     vec_valid,
    input  logic                     vec_ready,
    output logic [102:0]             vec_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         cap_count,
    output logic [15:0]              drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [102:0]     mem [DEPTH];

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cap_count_q, cap_count_d;

    logic             empty;
    logic             full;
    logic             do_rd;
    logic             do_wr;
    logic [102:0]     cap_word;

    assign empty = (wr_ptr_q == rd_ptr_q);
    // Same slot but different lap: the writer is one full lap ahead.
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[AW] != rd_ptr_q[AW]);

    assign cap_word = {ALUControl, a, b, Result, ALUFlags};

    assign vec_valid = !empty;
    assign vec_data  = mem[rd_ptr_q[AW-1:0]];
    assign level     = wr_ptr_q - rd_ptr_q;
    assign cap_count = cap_count_q;

`ifdef ALU_REC_DROP_EN
    logic        do_drop;
    logic [15:0] drop_count_q, drop_count_d;

    assign cap_ready  = 1'b1;
    assign drop_count = drop_count_q;

    always_comb begin
        do_rd   = !empty && vec_ready;
        // A read in the same cycle frees a slot, so a capture at full fits.
        do_wr   = cap_valid && (!full || do_rd);
        do_drop = cap_valid && full && !do_rd;
        drop_count_d = drop_count_q;
        if (do_drop && (drop_count_q != 16'hFFFF)) begin
            drop_count_d = drop_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_count_q <= '0;
        end else begin
            drop_count_q <= drop_count_d;
        end
    end
`else
    // Full is a decode of registered pointers only, so no path from vec_ready.
    assign cap_ready  = !full;
    assign drop_count = 16'd0;

    always_comb begin
        do_rd = !empty && vec_ready;
        do_wr = cap_valid && !full;
    end
`endif

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cap_count_d = cap_count_q;
        if (do_wr) begin
            wr_ptr_d    = wr_ptr_q + PW'(1);
            cap_count_d = cap_count_q + CNT_W'(1);
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cap_count_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cap_count_q <= cap_count_d;
        end
    end

    // Storage is not reset; stale words are hidden behind the pointers.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_q[AW-1:0]] <= cap_word;
        end
    end

endmodule
